// File: rtl/id_decode_stage_pkg.sv
// Shared encodings for the RV32I integer-ALU decode stage: ALU opcodes,
// major opcodes, funct3/funct7 values and the funct3-to-ALU mapping.
package id_decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLT = 4'd2,
        ALU_LUI = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB / SRA; it only has meaning for funct3 000 and 101
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLT;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_decode_stage_imm_gen.sv
// I-type (sign-extended 12-bit) and U-type (upper 20-bit) immediate generator.
module id_imm_gen
    import id_decode_stage_pkg::*;
(
    input  logic [31:12] i_instr_hi,
    output logic [31:0]  o_imm_i,
    output logic [31:0]  o_imm_u
);

    assign o_imm_i = {{20{i_instr_hi[31]}}, i_instr_hi[31:20]};
    assign o_imm_u = {i_instr_hi[31:12], 12'b0};

endmodule

// File: rtl/id_decode_stage.sv
// RV32I integer-ALU decode with one-level EX forwarding and the ID/EX
// pipeline register behind a valid/ready handshake.
module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_op,
    output logic            ex_is_signed,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_illegal
);

    logic            r_valid;
    logic [3:0]      r_alu_op;
    logic            r_is_signed;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_illegal;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic            w_is_shift;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    alu_op_e         w_alu_op;
    logic            w_is_signed;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_legal;
    logic            w_reg_write;

    assign w_opcode   = if_instr[6:0];
    assign w_rd       = if_instr[11:7];
    assign w_funct3   = if_instr[14:12];
    assign w_funct7   = if_instr[31:25];
    assign rs1_addr   = if_instr[19:15];
    assign rs2_addr   = if_instr[24:20];
    assign w_is_shift = (w_funct3 == F3_SLL) | (w_funct3 == F3_SRL_SRA);

    id_imm_gen u_imm_gen (
        .i_instr_hi (if_instr[31:12]),
        .o_imm_i    (w_imm_i),
        .o_imm_u    (w_imm_u)
    );

    // A stalled producer still forwards: qualification ignores ex_ready
    assign w_rs1_fwd = (r_valid & r_reg_write & (r_rd == rs1_addr) & (rs1_addr != 5'd0))
                       ? ex_result : rs1_data;
    assign w_rs2_fwd = (r_valid & r_reg_write & (r_rd == rs2_addr) & (rs2_addr != 5'd0))
                       ? ex_result : rs2_data;

    // Instruction decode into the ALU operand/opcode bundle
    always_comb begin
        w_alu_op    = ALU_ADD;
        w_is_signed = 1'b0;
        w_a         = {XLEN{1'b0}};
        w_b         = {XLEN{1'b0}};
        w_legal     = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_alu_op    = f3_to_alu(w_funct3, w_funct7 == F7_ALT);
                w_is_signed = (w_funct3 == F3_SLT);
                w_a         = w_rs1_fwd;
                if (w_is_shift) begin
                    w_b = {{(XLEN-5){1'b0}}, w_rs2_fwd[4:0]};
                end else begin
                    w_b = w_rs2_fwd;
                end
                w_legal = (w_funct7 == F7_BASE) |
                          ((w_funct7 == F7_ALT) &
                           ((w_funct3 == F3_ADD_SUB) | (w_funct3 == F3_SRL_SRA)));
            end
            OPC_OP_IMM: begin
                // imm bit 30 only means "arithmetic" for right shifts
                w_alu_op    = f3_to_alu(w_funct3,
                                        (w_funct3 == F3_SRL_SRA) & (w_funct7 == F7_ALT));
                w_is_signed = (w_funct3 == F3_SLT);
                w_a         = w_rs1_fwd;
                if (w_is_shift) begin
                    w_b     = {{(XLEN-5){1'b0}}, rs2_addr};
                    w_legal = (w_funct7 == F7_BASE) |
                              ((w_funct7 == F7_ALT) & (w_funct3 == F3_SRL_SRA));
                end else begin
                    w_b     = w_imm_i;
                    w_legal = 1'b1;
                end
            end
            OPC_LUI: begin
                w_alu_op = ALU_LUI;
                w_b      = w_imm_u;
                w_legal  = 1'b1;
            end
            OPC_AUIPC: begin
                w_alu_op = ALU_ADD;
                w_a      = if_pc;
                w_b      = w_imm_u;
                w_legal  = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
        w_reg_write = w_legal & (w_rd != 5'd0);
    end

    assign id_ready = ~r_valid | ex_ready;

    // ID/EX pipeline register: flush beats load, load beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu_op    <= 4'd0;
            r_is_signed <= 1'b0;
            r_a         <= {XLEN{1'b0}};
            r_b         <= {XLEN{1'b0}};
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (if_valid & id_ready) begin
            r_valid     <= 1'b1;
            r_alu_op    <= w_alu_op;
            r_is_signed <= w_is_signed;
            r_a         <= w_a;
            r_b         <= w_b;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_illegal   <= ~w_legal;
        end else if (ex_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_alu_op    = r_alu_op;
    assign ex_is_signed = r_is_signed;
    assign ex_a         = r_a;
    assign ex_b         = r_b;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_reg_write;
    assign ex_illegal   = r_illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Randomized + directed bench for id_decode_stage against an instruction-level
// reference model of the decode, forwarding and handshake rules.
module tb_id_decode_stage;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd2, A_LUI = 4'd3,
                           A_AND = 4'd4, A_OR = 4'd5, A_XOR = 4'd6, A_SLL = 4'd7,
                           A_SRL = 4'd8, A_SRA = 4'd9;

    typedef struct packed {
        logic [3:0]  alu;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] ex_result;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic        ex_is_signed;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_illegal;

    logic [31:0] rf [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_valid;
    bundle_t     m;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    id_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_ready(id_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_result(ex_result),
        .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
        .ex_alu_op(ex_alu_op), .ex_is_signed(ex_is_signed), .ex_a(ex_a), .ex_b(ex_b),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-level meaning of one RV32I word, operands already forwarded
    function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                             input logic [31:0] r1, input logic [31:0] r2);
        bundle_t     d;
        logic [3:0]  tab [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        shift;
        logic        legal;
        tab = '{A_ADD, A_SLL, A_SLT, A_SLT, A_XOR, A_SRL, A_OR, A_AND};
        f3 = ins[14:12];
        f7 = ins[31:25];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        d = '0;
        legal = 1'b0;
        if (ins[6:0] == 7'h33) begin
            d.alu = tab[f3];
            if (f7 == 7'h20 && f3 == 3'd0) d.alu = A_SUB;
            if (f7 == 7'h20 && f3 == 3'd5) d.alu = A_SRA;
            d.sgn = (f3 == 3'd2);
            d.a = r1;
            d.b = shift ? (r2 % 32) : r2;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (ins[6:0] == 7'h13) begin
            d.alu = tab[f3];
            if (f7 == 7'h20 && f3 == 3'd5) d.alu = A_SRA;
            d.sgn = (f3 == 3'd2);
            d.a = r1;
            d.b = shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
            legal = !shift || (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
        end else if (ins[6:0] == 7'h37) begin
            d.alu = A_LUI;
            d.b = ins & 32'hFFFFF000;
            legal = 1'b1;
        end else if (ins[6:0] == 7'h17) begin
            d.alu = A_ADD;
            d.a = pc;
            d.b = ins & 32'hFFFFF000;
            legal = 1'b1;
        end
        d.rd  = ins[11:7];
        d.ill = !legal;
        d.rw  = legal && (ins[11:7] != 5'd0);
        return d;
    endfunction

    // One clock: check combinational outputs, advance model, check registered outputs
    task automatic step();
        bundle_t     d;
        logic [31:0] r1, r2;
        logic [4:0]  s1, s2;
        if (!rst_n) begin
            m_valid = 1'b0;
            m = '0;
        end
        #1;
        s1 = if_instr[19:15];
        s2 = if_instr[24:20];
        chk("id_ready", 32'(id_ready), 32'(!m_valid || ex_ready));
        chk("rs1_addr", 32'(rs1_addr), 32'(s1));
        chk("rs2_addr", 32'(rs2_addr), 32'(s2));
        r1 = (m_valid && m.rw && m.rd == s1 && s1 != 5'd0) ? ex_result : rf[s1];
        r2 = (m_valid && m.rw && m.rd == s2 && s2 != 5'd0) ? ex_result : rf[s2];
        d = model_decode(if_instr, if_pc, r1, r2);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (if_valid && (!m_valid || ex_ready)) begin
            m_valid = 1'b1;
            m = d;
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_alu_op", 32'(ex_alu_op), 32'(m.alu));
        chk("ex_is_signed", 32'(ex_is_signed), 32'(m.sgn));
        chk("ex_a", ex_a, m.a);
        chk("ex_b", ex_b, m.b);
        chk("ex_rd", 32'(ex_rd), 32'(m.rd));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc, f7;
        int         sel, fs;
        sel = int'($urandom_range(0, 9));
        if (sel <= 3)      opc = 7'h33;
        else if (sel <= 6) opc = 7'h13;
        else if (sel == 7) opc = 7'h37;
        else if (sel == 8) opc = 7'h17;
        else               opc = 7'($urandom);
        fs = int'($urandom_range(0, 3));
        f7 = (fs <= 1) ? 7'h00 : (fs == 2) ? 7'h20 : 7'($urandom);
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), opc};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        ex_result = 32'd0; ex_ready = 1'b1; flush = 1'b0;
        m_valid = 1'b0; m = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_a", ex_a, 32'd0);
        chk("rst_b", ex_b, 32'd0);
        chk("rst_ready", 32'(id_ready), 32'd1);

        // addi x1,x0,-5
        if_valid = 1'b1; if_instr = 32'hFFB00093; rf[1] = 32'h00001234;
        step();
        chk("addi_alu", 32'(ex_alu_op), 32'd0);
        chk("addi_a", ex_a, 32'd0);
        chk("addi_b", ex_b, 32'hFFFFFFFB);
        chk("addi_rd", 32'(ex_rd), 32'd1);
        chk("addi_rw", 32'(ex_reg_write), 32'd1);

        // sub x2,x1,x1 forwarding from the addi in EX
        if_instr = 32'h40108133; ex_result = 32'hFFFFFFFB;
        step();
        chk("sub_alu", 32'(ex_alu_op), 32'd1);
        chk("sub_a", ex_a, 32'hFFFFFFFB);
        chk("sub_b", ex_b, 32'hFFFFFFFB);

        if_instr = 32'h41F25193;   // srai x3,x4,31
        step();
        chk("srai_alu", 32'(ex_alu_op), 32'd9);
        chk("srai_b", ex_b, 32'd31);

        if_instr = 32'h007332B3;   // sltu x5,x6,x7
        step();
        chk("sltu_alu", 32'(ex_alu_op), 32'd2);
        chk("sltu_signed", 32'(ex_is_signed), 32'd0);

        if_instr = 32'h12345437;   // lui x8,0x12345
        step();
        chk("lui_alu", 32'(ex_alu_op), 32'd3);
        chk("lui_a", ex_a, 32'd0);
        chk("lui_b", ex_b, 32'h12345000);

        if_instr = 32'h00001497; if_pc = 32'h00000100;   // auipc x9,1
        step();
        chk("auipc_alu", 32'(ex_alu_op), 32'd0);
        chk("auipc_a", ex_a, 32'h00000100);
        chk("auipc_b", ex_b, 32'h00001000);

        // Three-cycle EX stall with fetch still presenting
        ex_ready = 1'b0; if_instr = 32'hFFB00093;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_b", ex_b, 32'h00001000);
            chk("stall_valid", 32'(ex_valid), 32'd1);
            chk("stall_ready", 32'(id_ready), 32'd0);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        flush = 1'b0; ex_ready = 1'b1;

        if_instr = 32'h4020C0B3;   // funct7=0100000 with funct3=100
        step();
        chk("f7_illegal", 32'(ex_illegal), 32'd1);
        chk("f7_rw", 32'(ex_reg_write), 32'd0);
        if_instr = 32'h00012083;   // opcode 0000011
        step();
        chk("opc_illegal", 32'(ex_illegal), 32'd1);
        chk("opc_rw", 32'(ex_reg_write), 32'd0);
        chk("opc_a", ex_a, 32'd0);
        chk("opc_b", ex_b, 32'd0);

        // Randomized traffic with stalls, flushes and occasional mid-run reset
        for (int n = 0; n < 500; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            if_valid  = ($urandom_range(0, 9) < 7);
            ex_ready  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            if_instr  = rand_instr();
            if_pc     = $urandom;
            ex_result = $urandom;
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(1, 31)] = $urandom;
            step();
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
